// File: rtl/trace_pkg.sv
// trace_pkg: shared definitions for the commit-trace capture block.
//   - record type codes (register write / memory store)
//   - record geometry (48-bit record, sent as 6 bytes)
//   - serializer state encoding
//   - pack_record(): builds one record from type, address and data
package trace_pkg;

    localparam logic [1:0] TYPE_REG = 2'b01;
    localparam logic [1:0] TYPE_MEM = 2'b10;

    localparam int RECORD_W     = 48;
    localparam int RECORD_BYTES = 6;

    typedef enum logic {
        SER_IDLE,
        SER_SEND
    } ser_state_t;

    // Record layout: [47:46] type, [45:44] reserved zero, [43:32] address,
    // [31:0] data. Register indices arrive zero-extended in addr.
    function automatic logic [RECORD_W-1:0] pack_record(
        input logic [1:0]  rec_type,
        input logic [11:0] addr,
        input logic [31:0] value
    );
        return {rec_type, 2'b00, addr, value};
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: DEPTH x RECORD_W circular buffer with two ordered push ports
// and one pop port. push0 is always placed ahead of push1 in the same cycle.
// A pop in the same cycle frees a slot that this cycle's pushes may use.
//   clock, reset     : clock, asynchronous active-low reset
//   push0/data0      : first push request and record
//   push1/data1      : second push request and record
//   accept0/accept1  : the corresponding push fits and is written this cycle
//   pop              : remove the head entry (ignored when empty)
//   head             : record at the head of the buffer
//   empty            : no entries stored
//   level            : number of stored entries (0..DEPTH)
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push0,
    input  logic [RECORD_W-1:0]     data0,
    input  logic                    push1,
    input  logic [RECORD_W-1:0]     data1,
    output logic                    accept0,
    output logic                    accept1,
    input  logic                    pop,
    output logic [RECORD_W-1:0]     head,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW+1:0] DEPTH_SLOTS = DEPTH[AW+1:0];

    logic [RECORD_W-1:0] mem [DEPTH];

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] wr_idx1;
    logic [AW+1:0] free_slots;
    logic [1:0]    push_cnt;
    logic          do_pop;

    assign level  = wr_ptr - rd_ptr;
    assign empty  = (wr_ptr == rd_ptr);
    assign do_pop = pop & ~empty;
    assign head   = mem[rd_ptr[AW-1:0]];

    // Slots available to this cycle's pushes, counting the slot a
    // simultaneous pop releases.
    assign free_slots = DEPTH_SLOTS - {1'b0, level} + {{(AW+1){1'b0}}, do_pop};

    assign accept0  = push0 & (free_slots != '0);
    assign accept1  = push1 & (free_slots > {{(AW+1){1'b0}}, accept0});
    assign wr_idx1  = wr_ptr[AW-1:0] + {{(AW-1){1'b0}}, accept0};
    assign push_cnt = {1'b0, accept0} + {1'b0, accept1};

    // NOTE: the storage array has no reset; entries are only read after
    // being written, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clock) begin
        if (accept0) mem[wr_ptr[AW-1:0]] <= data0;
        if (accept1) mem[wr_idx1]        <= data1;
    end

    // NOTE: flop state uses non-blocking assignments so every process reads
    // the pre-edge values regardless of evaluation order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, push_cnt};
            rd_ptr <= rd_ptr + {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/commit_trace.sv
// commit_trace: captures regfile writes and dmem stores as 48-bit records,
// buffers them, and streams them out MSB byte first over valid/ready.
//   clock, reset          : processor clock, asynchronous active-low reset
//   trace_en              : enables capture (serializer drains regardless)
//   ctrl_writeEnable      : regfile write strobe
//   ctrl_writeReg         : regfile destination index
//   data_writeReg         : regfile write data
//   wren                  : dmem write strobe
//   address_dmem, data    : dmem store address and data
//   tx_data, tx_valid     : outgoing byte and its valid flag
//   tx_ready              : consumer accepts the byte this cycle
//   fifo_level            : buffered records (excludes the one being sent)
//   overflow              : sticky, at least one record was dropped
//   drop_count            : dropped records, saturating at 16'hFFFF
//   clear_overflow        : synchronous clear of overflow and drop_count
module commit_trace
    import trace_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter bit TRACE_R0 = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    trace_en,
    input  logic                    ctrl_writeEnable,
    input  logic [4:0]              ctrl_writeReg,
    input  logic [31:0]             data_writeReg,
    input  logic                    wren,
    input  logic [11:0]             address_dmem,
    input  logic [31:0]             data,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    overflow,
    output logic [15:0]             drop_count,
    input  logic                    clear_overflow
);

    localparam logic [2:0] LAST_BYTE = 3'(RECORD_BYTES - 1);

    logic                reg_event;
    logic                mem_event;
    logic [RECORD_W-1:0] reg_record;
    logic [RECORD_W-1:0] mem_record;
    logic                reg_accept;
    logic                mem_accept;
    logic                fifo_pop;
    logic                fifo_empty;
    logic [RECORD_W-1:0] fifo_head;

    logic [1:0]          drop_n;
    logic [15:0]         drop_base;
    logic [16:0]         drop_sum;

    ser_state_t          state;
    ser_state_t          next_state;
    logic [RECORD_W-1:0] shift_reg;
    logic [2:0]          byte_idx;
    logic                load;
    logic                advance;

    // Writes to r0 are architecturally invisible; they are skipped unless
    // TRACE_R0 asks for them, and skipping them is not a drop.
    assign reg_event = trace_en & ctrl_writeEnable &
                       (TRACE_R0 | (ctrl_writeReg != 5'd0));
    assign mem_event = trace_en & wren;

    assign reg_record = pack_record(TYPE_REG, {7'd0, ctrl_writeReg}, data_writeReg);
    assign mem_record = pack_record(TYPE_MEM, address_dmem, data);

    // Register record goes on push0 so it lands ahead of a same-cycle store
    // and is the one kept when only a single slot is free.
    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push0   (reg_event),
        .data0   (reg_record),
        .push1   (mem_event),
        .data1   (mem_record),
        .accept0 (reg_accept),
        .accept1 (mem_accept),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // ---------------------------------------------------------------
    // Drop accounting. A drop in the same cycle as clear_overflow wins:
    // the count restarts from zero and then takes this cycle's drops.
    // ---------------------------------------------------------------
    assign drop_n    = {1'b0, reg_event & ~reg_accept} + {1'b0, mem_event & ~mem_accept};
    assign drop_base = clear_overflow ? 16'h0000 : drop_count;
    assign drop_sum  = {1'b0, drop_base} + {15'd0, drop_n};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            drop_count <= 16'h0000;
        end else if (drop_n != 2'd0) begin
            overflow   <= 1'b1;
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= 16'h0000;
        end
    end

    // ---------------------------------------------------------------
    // Serializer. Loading pops the FIFO head into the shift register;
    // the last byte's handshake reloads directly so records run
    // back-to-back without an idle cycle.
    // ---------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= SER_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        fifo_pop   = 1'b0;
        load       = 1'b0;
        advance    = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        case (state)
            SER_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    load       = 1'b1;
                    next_state = SER_SEND;
                end
            end
            SER_SEND: begin
                tx_valid = 1'b1;
                tx_data  = shift_reg[RECORD_W-1 -: 8];
                if (tx_ready) begin
                    if (byte_idx == LAST_BYTE) begin
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            load     = 1'b1;
                        end else begin
                            next_state = SER_IDLE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: next_state = SER_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            byte_idx  <= '0;
        end else if (load) begin
            shift_reg <= fifo_head;
            byte_idx  <= '0;
        end else if (advance) begin
            shift_reg <= {shift_reg[RECORD_W-9:0], 8'h00};
            byte_idx  <= byte_idx + 3'd1;
        end
    end

endmodule
